// File: rtl/rom_dl_responder_if.sv
// rom_dl_responder_if
//   Bundles the two sides of rom_dl_responder:
//   - initiator side: toggle handshake (port_req/port_ack) carrying a word
//     address, byte strobes, write flag and write data, plus read data port_q;
//   - memory side: command bus (mem_req/mem_addr/mem_ds/mem_we/mem_d), its
//     accept strobe mem_rdy and the read return mem_q/mem_qvalid.
//   Modports:
//   - slave:  the responder's view.
//   - master: the view of the initiator and memory that surround it.
interface rom_dl_responder_if #(
  parameter int unsigned AW = 23
);
  // Initiator side
  logic          port_req;
  logic          port_ack;
  logic [AW-1:0] port_a;
  logic [1:0]    port_ds;
  logic          port_we;
  logic [15:0]   port_d;
  logic [15:0]   port_q;
  // Memory side
  logic          mem_req;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_ds;
  logic          mem_we;
  logic [15:0]   mem_d;
  logic          mem_rdy;
  logic [15:0]   mem_q;
  logic          mem_qvalid;

  modport slave (
    input  port_req, port_a, port_ds, port_we, port_d, mem_rdy, mem_q, mem_qvalid,
    output port_ack, port_q, mem_req, mem_addr, mem_ds, mem_we, mem_d
  );

  modport master (
    output port_req, port_a, port_ds, port_we, port_d, mem_rdy, mem_q, mem_qvalid,
    input  port_ack, port_q, mem_req, mem_addr, mem_ds, mem_we, mem_d
  );
endinterface

// File: rtl/rom_dl_responder.sv
// rom_dl_responder
//   Bridges a toggle-handshake initiator to a memory command bus. Writes are
//   posted into a FIFO and acknowledged one cycle after they are queued; reads
//   are queued in order behind earlier writes and acknowledged one cycle after
//   their data returns. The FIFO head is issued to memory by a three-state FSM
//   (IDLE -> ISSUE -> IDLE, or ISSUE -> RDWAIT -> IDLE for reads).
//   Optional feature: define ROM_DL_RESPONDER_WRITE_MERGE_EN to merge a write
//   into the tail entry when the tail is a write to the same address.
//   Ports:
//   - clk_sys : sole clock, rising edge.
//   - reset_n : asynchronous active-low reset.
//   - bus     : rom_dl_responder_if.slave (initiator handshake + memory bus).
//   - busy    : FIFO non-empty or FSM not idle.
module rom_dl_responder #(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned AW         = 23
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  rom_dl_responder_if.slave bus,
  output logic              busy
);

  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CntW-1:0] CntFull = CntW'(FIFO_DEPTH);

  localparam logic [1:0] StIdle   = 2'd0;
  localparam logic [1:0] StIssue  = 2'd1;
  localparam logic [1:0] StRdWait = 2'd2;

  logic [1:0]      state_q, state_d;
  logic            req_seen_q, req_seen_d;
  logic            port_ack_q, port_ack_d;
  logic [15:0]     port_q_q, port_q_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Entry storage carries no reset: only entries counted by count_q are used.
  logic [AW-1:0]   fifo_addr_q [FIFO_DEPTH];
  logic [1:0]      fifo_ds_q   [FIFO_DEPTH];
  logic            fifo_we_q   [FIFO_DEPTH];
  logic [15:0]     fifo_d_q    [FIFO_DEPTH];

  logic req_pend, fifo_empty, fifo_full, merge, push, pop, accept, wr_ack, rd_done, issue;

  assign req_pend   = bus.port_req != req_seen_q;
  assign fifo_empty = count_q == '0;
  assign fifo_full  = count_q == CntFull;

`ifdef ROM_DL_RESPONDER_WRITE_MERGE_EN
  logic [PtrW-1:0] tail_ptr;
  assign tail_ptr = wr_ptr_q - PtrW'(1);
  // The head in ISSUE is already driving the memory bus, so it must not change.
  assign merge = req_pend && bus.port_we && !fifo_empty && fifo_we_q[tail_ptr] &&
                 (fifo_addr_q[tail_ptr] == bus.port_a) &&
                 !((state_q == StIssue) && (tail_ptr == rd_ptr_q));
`else
  assign merge = 1'b0;
`endif

  // Full is judged on the start-of-cycle count; a same-cycle pop does not help.
  assign push    = req_pend && !merge && !fifo_full;
  assign accept  = push || merge;
  assign issue   = state_q == StIssue;
  assign pop     = issue && bus.mem_rdy;
  assign rd_done = (state_q == StRdWait) && bus.mem_qvalid;
  assign wr_ack  = accept && bus.port_we;

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:   if (!fifo_empty) state_d = StIssue;
      StIssue:  if (bus.mem_rdy) state_d = fifo_we_q[rd_ptr_q] ? StIdle : StRdWait;
      StRdWait: if (bus.mem_qvalid) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  always_comb begin
    req_seen_d = accept ? bus.port_req : req_seen_q;
    port_ack_d = port_ack_q ^ wr_ack ^ rd_done;
    port_q_d   = rd_done ? bus.mem_q : port_q_q;
    wr_ptr_d   = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;
    count_d    = count_q + CntW'(push) - CntW'(pop);
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StIdle;
      req_seen_q <= 1'b0;
      port_ack_q <= 1'b0;
      port_q_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_seen_q <= req_seen_d;
      port_ack_q <= port_ack_d;
      port_q_q   <= port_q_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.port_a;
      fifo_ds_q[wr_ptr_q]   <= bus.port_ds;
      fifo_we_q[wr_ptr_q]   <= bus.port_we;
      fifo_d_q[wr_ptr_q]    <= bus.port_d;
    end
`ifdef ROM_DL_RESPONDER_WRITE_MERGE_EN
    else if (merge) begin
      fifo_ds_q[tail_ptr] <= fifo_ds_q[tail_ptr] | bus.port_ds;
      if (bus.port_ds[0]) fifo_d_q[tail_ptr][7:0]  <= bus.port_d[7:0];
      if (bus.port_ds[1]) fifo_d_q[tail_ptr][15:8] <= bus.port_d[15:8];
    end
`endif
  end

  // The command bus shows the head entry only while issuing, zero otherwise.
  assign bus.mem_req  = issue;
  assign bus.mem_addr = issue ? fifo_addr_q[rd_ptr_q] : '0;
  assign bus.mem_ds   = issue ? fifo_ds_q[rd_ptr_q]   : '0;
  assign bus.mem_we   = issue ? fifo_we_q[rd_ptr_q]   : 1'b0;
  assign bus.mem_d    = issue ? fifo_d_q[rd_ptr_q]    : '0;

  assign bus.port_ack = port_ack_q;
  assign bus.port_q   = port_q_q;
  assign busy         = !fifo_empty || (state_q != StIdle);

endmodule

// File: tb/tb_rom_dl_responder.sv
// tb_rom_dl_responder
//   Table of single transactions (mem_rdy=1) followed by hand-written
//   sequences: byte-pair writes, full FIFO back-pressure, read behind writes,
//   stray read return, and reset during a read.
module tb_rom_dl_responder;
  localparam int unsigned AW        = 23;
  localparam int unsigned FifoDepth = 4;

  logic clk_sys = 1'b0;
  logic reset_n;
  logic busy;

  always #5 clk_sys = ~clk_sys;

  rom_dl_responder_if #(.AW(AW)) bus ();

  rom_dl_responder #(
    .FIFO_DEPTH(FifoDepth),
    .AW        (AW)
  ) dut (
    .clk_sys(clk_sys),
    .reset_n(reset_n),
    .bus    (bus),
    .busy   (busy)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic          we;
    logic [15:0]   d;
  } cmd_t;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [1:0]    ds;
    logic [15:0]   d;
    logic [15:0]   rq;
    logic [AW-1:0] exp_a;
    logic [1:0]    exp_ds;
    logic [15:0]   exp_d;
    logic          exp_we;
    logic [15:0]   exp_q;
  } vec_t;

  cmd_t cmd_q[$];
  vec_t vecs[6];
  int   n_vec  = 0;
  int   n_fail = 0;
  logic exp_ack;

  // Record every accepted memory command, sampled mid-cycle.
  always @(negedge clk_sys) begin
    if (bus.mem_req && bus.mem_rdy) cmd_q.push_back({bus.mem_addr, bus.mem_ds, bus.mem_we, bus.mem_d});
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic send(input logic we, input logic [AW-1:0] a, input logic [1:0] ds,
                      input logic [15:0] d);
    bus.port_we  = we;
    bus.port_a   = a;
    bus.port_ds  = ds;
    bus.port_d   = d;
    bus.port_req = ~bus.port_req;
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [1:0] ds, input logic [15:0] d,
                          input string nm);
    send(1'b1, a, ds, d);
    tick();
    exp_ack = ~exp_ack;
    check({nm, "_ack"}, 32'(bus.port_ack), 32'(exp_ack));
    check({nm, "_busy"}, 32'(busy), 32'd1);
  endtask

  task automatic do_read(input logic [AW-1:0] a, input logic [1:0] ds, input logic [15:0] d,
                         input logic [15:0] rq, input string nm);
    int n;
    send(1'b0, a, ds, d);
    tick();
    check({nm, "_ack_at_enq"}, 32'(bus.port_ack), 32'(exp_ack));
    n = 0;
    while (!(bus.mem_req && !bus.mem_we) && n < 20) begin
      tick();
      n++;
    end
    check({nm, "_issue_seen"}, 32'(bus.mem_req && !bus.mem_we), 32'd1);
    tick();  // acceptance edge
    tick();
    tick();
    check({nm, "_ack_before_ret"}, 32'(bus.port_ack), 32'(exp_ack));
    bus.mem_q      = rq;
    bus.mem_qvalid = 1'b1;
    tick();
    bus.mem_qvalid = 1'b0;
    exp_ack = ~exp_ack;
    check({nm, "_ack_after_ret"}, 32'(bus.port_ack), 32'(exp_ack));
    check({nm, "_port_q"}, 32'(bus.port_q), 32'(rq));
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while (busy && n < 60) begin
      tick();
      n++;
    end
    check({nm, "_idle"}, 32'(busy), 32'd0);
  endtask

  initial begin
    vecs[0] = '{1'b1, 23'h000010, 2'b01, 16'h00AB, 16'h0000,
                23'h000010, 2'b01, 16'h00AB, 1'b1, 16'h0000};
    vecs[1] = '{1'b1, 23'h7FFFFF, 2'b11, 16'hFFFF, 16'h0000,
                23'h7FFFFF, 2'b11, 16'hFFFF, 1'b1, 16'h0000};
    vecs[2] = '{1'b1, 23'h123456, 2'b10, 16'h5A00, 16'h0000,
                23'h123456, 2'b10, 16'h5A00, 1'b1, 16'h0000};
    vecs[3] = '{1'b0, 23'h000020, 2'b11, 16'h0000, 16'hBEEF,
                23'h000020, 2'b11, 16'h0000, 1'b0, 16'hBEEF};
    vecs[4] = '{1'b0, 23'h000001, 2'b10, 16'h7777, 16'h1234,
                23'h000001, 2'b10, 16'h7777, 1'b0, 16'h1234};
    vecs[5] = '{1'b1, 23'h000000, 2'b00, 16'hC3C3, 16'h0000,
                23'h000000, 2'b00, 16'hC3C3, 1'b1, 16'h1234};

    reset_n        = 1'b0;
    bus.port_req   = 1'b0;
    bus.port_a     = '0;
    bus.port_ds    = '0;
    bus.port_we    = 1'b0;
    bus.port_d     = '0;
    bus.mem_rdy    = 1'b1;
    bus.mem_q      = '0;
    bus.mem_qvalid = 1'b0;
    exp_ack        = 1'b0;
    tick();
    tick();
    check("rst_ack", 32'(bus.port_ack), 32'd0);
    check("rst_q", 32'(bus.port_q), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_mem_bus", 32'({bus.mem_addr, bus.mem_ds, bus.mem_we, bus.mem_d}), 32'd0);
    reset_n = 1'b1;
    tick();
    check("post_rst_ack", 32'(bus.port_ack), 32'd0);
    check("post_rst_busy", 32'(busy), 32'd0);

    // Single transactions with memory always ready.
    foreach (vecs[i]) begin
      cmd_q.delete();
      if (vecs[i].we) do_write(vecs[i].a, vecs[i].ds, vecs[i].d, $sformatf("v%0d", i));
      else do_read(vecs[i].a, vecs[i].ds, vecs[i].d, vecs[i].rq, $sformatf("v%0d", i));
      wait_idle($sformatf("v%0d", i));
      check($sformatf("v%0d_ncmd", i), 32'(cmd_q.size()), 32'd1);
      if (cmd_q.size() >= 1) begin
        check($sformatf("v%0d_addr", i), 32'(cmd_q[0].a), 32'(vecs[i].exp_a));
        check($sformatf("v%0d_ds", i), 32'(cmd_q[0].ds), 32'(vecs[i].exp_ds));
        check($sformatf("v%0d_we", i), 32'(cmd_q[0].we), 32'(vecs[i].exp_we));
        check($sformatf("v%0d_d", i), 32'(cmd_q[0].d), 32'(vecs[i].exp_d));
      end
      check($sformatf("v%0d_port_q", i), 32'(bus.port_q), 32'(vecs[i].exp_q));
    end

    // Byte pair to one address while memory stalls.
    bus.mem_rdy = 1'b0;
    cmd_q.delete();
    do_write(23'h000040, 2'b01, 16'h0012, "bp_lo");
    do_write(23'h000040, 2'b10, 16'h3400, "bp_hi");
    tick();
    check("bp_mem_req_held", 32'(bus.mem_req), 32'd1);
    bus.mem_rdy = 1'b1;
    wait_idle("bp");
`ifdef ROM_DL_RESPONDER_WRITE_MERGE_EN
    check("bp_ncmd", 32'(cmd_q.size()), 32'd1);
    if (cmd_q.size() >= 1) begin
      check("bp_ds", 32'(cmd_q[0].ds), 32'h3);
      check("bp_d", 32'(cmd_q[0].d), 32'h3412);
    end
`else
    check("bp_ncmd", 32'(cmd_q.size()), 32'd2);
    if (cmd_q.size() >= 2) begin
      check("bp_ds0", 32'(cmd_q[0].ds), 32'h1);
      check("bp_d0", 32'(cmd_q[0].d), 32'h0012);
      check("bp_ds1", 32'(cmd_q[1].ds), 32'h2);
      check("bp_d1", 32'(cmd_q[1].d), 32'h3400);
    end
`endif

    // Fill the FIFO; the fifth write waits for the first pop.
    bus.mem_rdy = 1'b0;
    cmd_q.delete();
    for (int i = 0; i < 4; i++) do_write(23'h000100 + 23'(i), 2'b11, 16'hA000 + 16'(i),
                                         $sformatf("full_w%0d", i));
    send(1'b1, 23'h000104, 2'b11, 16'hA004);
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("full_ack_held%0d", i), 32'(bus.port_ack), 32'(exp_ack));
    end
    check("full_mem_addr", 32'(bus.mem_addr), 32'h000100);
    bus.mem_rdy = 1'b1;
    tick();  // pop edge, count was full
    check("full_no_enq_on_pop", 32'(bus.port_ack), 32'(exp_ack));
    tick();
    exp_ack = ~exp_ack;
    check("full_ack_late", 32'(bus.port_ack), 32'(exp_ack));
    wait_idle("full");
    check("full_ncmd", 32'(cmd_q.size()), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < cmd_q.size()) begin
        check($sformatf("full_order%0d_a", i), 32'(cmd_q[i].a), 32'h100 + 32'(i));
        check($sformatf("full_order%0d_d", i), 32'(cmd_q[i].d), 32'hA000 + 32'(i));
      end
    end

    // Read queued behind two writes.
    cmd_q.delete();
    do_write(23'h000200, 2'b01, 16'h0011, "rw_w0");
    do_write(23'h000201, 2'b10, 16'h2200, "rw_w1");
    do_read(23'h000020, 2'b11, 16'h0000, 16'hBEEF, "rw_rd");
    wait_idle("rw");
    check("rw_ncmd", 32'(cmd_q.size()), 32'd3);
    if (cmd_q.size() >= 3) begin
      check("rw_we_seq", 32'({cmd_q[0].we, cmd_q[1].we, cmd_q[2].we}), 32'b110);
      check("rw_rd_addr", 32'(cmd_q[2].a), 32'h20);
    end

    // A read return outside RDWAIT has no effect.
    bus.mem_q      = 16'hDEAD;
    bus.mem_qvalid = 1'b1;
    tick();
    bus.mem_qvalid = 1'b0;
    tick();
    check("stray_ret_q", 32'(bus.port_q), 32'hBEEF);
    check("stray_ret_ack", 32'(bus.port_ack), 32'(exp_ack));

`ifdef ROM_DL_RESPONDER_WRITE_MERGE_EN
    // A merge proceeds while the FIFO is full.
    bus.mem_rdy = 1'b0;
    cmd_q.delete();
    for (int i = 0; i < 4; i++) do_write(23'h000400 + 23'(i), 2'b11, 16'h5500 + 16'(i),
                                         $sformatf("mf_w%0d", i));
    do_write(23'h000403, 2'b01, 16'h00EE, "mf_merge");
    bus.mem_rdy = 1'b1;
    wait_idle("mf");
    check("mf_ncmd", 32'(cmd_q.size()), 32'd4);
    if (cmd_q.size() >= 4) check("mf_d", 32'(cmd_q[3].d), 32'h55EE);
`endif

    do_write(23'h000300, 2'b11, 16'h1111, "pre_rst_w");
    wait_idle("pre_rst");

    // Reset while a read is outstanding.
    send(1'b0, 23'h000030, 2'b11, 16'h0000);
    tick();
    begin
      int n;
      n = 0;
      while (!bus.mem_req && n < 20) begin
        tick();
        n++;
      end
    end
    check("mr_issue_seen", 32'(bus.mem_req), 32'd1);
    tick();  // acceptance edge, now waiting for data
    check("mr_req_drop", 32'(bus.mem_req), 32'd0);
    check("mr_busy_rdwait", 32'(busy), 32'd1);
    reset_n      = 1'b0;
    bus.port_req = 1'b0;
    #1;
    check("mr_async_ack", 32'(bus.port_ack), 32'd0);
    check("mr_async_q", 32'(bus.port_q), 32'd0);
    check("mr_async_busy", 32'(busy), 32'd0);
    tick();
    reset_n = 1'b1;
    exp_ack = 1'b0;
    tick();
    bus.mem_q      = 16'h5555;
    bus.mem_qvalid = 1'b1;
    tick();
    bus.mem_qvalid = 1'b0;
    tick();
    check("mr_ack", 32'(bus.port_ack), 32'd0);
    check("mr_busy", 32'(busy), 32'd0);
    check("mr_q", 32'(bus.port_q), 32'd0);
    check("mr_mem_req", 32'(bus.mem_req), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule

// File: doc/rom_dl_responder.md
ROM_DL_RESPONDER -- requirements
Module: rom_dl_responder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4: posted-write FIFO entries, power of two, 2 to 16.
REQ-002 SHALL have parameter AW, default 23: word-address width.
REQ-003 SHALL have port clk_sys, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: reset, asynchronous, active-low.
REQ-005 SHALL have port port_req, input, 1: request toggle; a new request is any change in level.
REQ-006 SHALL have port port_ack, output, 1: acknowledge toggle; equals port_req when no request is outstanding.
REQ-007 SHALL have port port_a, input, AW: word address, sampled at request detection.
REQ-008 SHALL have port port_ds, input, 2: byte strobes, [1]=d[15:8], [0]=d[7:0].
REQ-009 SHALL have port port_we, input, 1: 1=write, 0=read.
REQ-010 SHALL have port port_d, input, 16: write data.
REQ-011 SHALL have port port_q, output, 16: read data, valid from the ack toggle until the next read completes.
REQ-012 SHALL have ports mem_req (output, 1), mem_addr (output, AW), mem_ds (output, 2), mem_we (output, 1) and mem_d (output, 16): memory command bus, held stable while mem_req=1.
REQ-013 SHALL have port mem_rdy, input, 1: command accepted in any cycle where mem_req and mem_rdy are both 1.
REQ-014 SHALL have ports mem_q (input, 16) and mem_qvalid (input, 1): read return, one-cycle pulse.
REQ-015 SHALL have port busy, output, 1: set when the FIFO is non-empty or the state is not IDLE.

Function
REQ-016 SHALL detect a request when port_req differs from the internal req_seen register; detection is also gated by the conditions in REQ-017 and REQ-018.
REQ-017 SHALL enqueue a detected request only when count<FIFO_DEPTH at the start of the cycle; no enqueue on full even if a dequeue occurs that cycle.
  - When the request is accepted, req_seen SHALL update to port_req.
REQ-018 Write: SHALL toggle port_ack in the cycle after enqueue (1-cycle latency); when the FIFO is full, the request SHALL stay pending and the ack SHALL be delayed.
REQ-019 Read: SHALL enqueue in order behind earlier writes, with no ack at enqueue.
  - port_ack SHALL toggle, and port_q SHALL load mem_q, in the cycle after mem_qvalid.
REQ-020 State machine: IDLE, ISSUE, RDWAIT.
  - IDLE->ISSUE when the FIFO is non-empty; the head entry drives the mem_* bus.
  - ISSUE SHALL hold mem_req=1 until mem_rdy=1, then pop the head.
  - ISSUE->IDLE for a write; ISSUE->RDWAIT for a read.
  - RDWAIT->IDLE on mem_qvalid.
REQ-021 SHALL ignore mem_qvalid outside RDWAIT.
REQ-022 FIFO pointers SHALL wrap modulo FIFO_DEPTH; count width SHALL be clog2(FIFO_DEPTH)+1.
REQ-023 Simultaneous enqueue and dequeue SHALL leave count unchanged and move both pointers.
REQ-024 mem_req SHALL deassert in the cycle after acceptance; back-to-back commands SHALL have at least one IDLE cycle between them.
REQ-025 A second port_req toggle before port_ack matches is a protocol violation; the behaviour is unspecified and is not checked.

Reset
REQ-026 On reset_n=0, asynchronously:
  - port_ack=0, req_seen=0, port_q=0.
  - mem_req=0, mem_we=0, mem_ds=0, mem_addr=0, mem_d=0.
  - busy=0, FIFO empty, state IDLE.
REQ-027 Reset mid-operation SHALL discard queued and in-flight entries; a read return arriving after release SHALL be ignored.
REQ-028 The initiator is reset in the same domain, so port_req=0 after release.

Configuration
REQ-029 Macro ROM_DL_RESPONDER_WRITE_MERGE_EN SHALL control write merging.
  - Defined: an incoming write SHALL merge into the tail entry instead of enqueuing when all of these hold:
    - the tail entry is a write;
    - port_a equals the tail address;
    - the tail entry is not the head in ISSUE.
  - On merge: tail ds |= port_ds, and the tail data byte lanes selected by port_ds are replaced.
  - A merge SHALL not change count, SHALL ack in 1 cycle, and SHALL proceed even when the FIFO is full.
  - Undefined: every write SHALL occupy its own entry.

Verification
REQ-030 Single write: toggle port_req with a=0x000010, ds=01, d=0x00AB, mem_rdy=1 -> port_ack toggles 1 cycle later; one command a=0x000010, ds=01, we=1.
REQ-031 Byte pair, mem_rdy=0: write ds=01 d=0x0012, then ds=10 d=0x3400, same address.
  - Without macro: two commands.
  - With macro: one command, ds=11, d=0x3412.
REQ-032 Full FIFO: mem_rdy=0 and 5 writes to distinct addresses (FIFO_DEPTH=4).
  - The 4th ack arrives and the 5th ack is withheld.
  - Raising mem_rdy -> the 5th ack toggles after the first pop; order is preserved.
REQ-033 Read after writes: 2 writes then a read of a=0x000020; mem_qvalid returns mem_q=0xBEEF 3 cycles after acceptance.
  - Read ack toggles only after the read return; port_q=0xBEEF.
REQ-034 Reset mid-read: drive reset_n low during RDWAIT, then pulse mem_qvalid after release.
  - Result: port_ack=0, busy=0, port_q=0, mem_req=0.
